// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the mux select arbiter.
// The master drives requests; the slave (arbiter) returns select and grant.
interface mux_sel_arbiter_if;
  logic [2:0] req;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       gnt_valid;

  modport master (
    output req,
    input  sel,
    input  gnt,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output sel,
    output gnt,
    output gnt_valid
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Registered round-robin arbiter with a burst limit per grant.
// Drives the 2-bit select of a 3-input mux and never produces 2'b11.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_arbiter_if.slave  bus
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [1:0]        last_owner, last_owner_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [1:0]        sel_q, sel_n;
  logic [2:0]        gnt_q, gnt_n;
  logic              vld_q, vld_n;

  logic              found;
  logic [1:0]        win;
  logic              owner_req;

  // Search order from last owner L is L+1, L+2, L (mod 3); only 0..2 are ever produced.
  function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
    logic [2:0] res;
    res = 3'b000;
    case (last)
      2'd0: begin
        if      (r[1]) res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
      end
      2'd1: begin
        if      (r[2]) res = {1'b1, 2'd2};
        else if (r[0]) res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
      end
      default: begin
        if      (r[0]) res = {1'b1, 2'd0};
        else if (r[1]) res = {1'b1, 2'd1};
        else if (r[2]) res = {1'b1, 2'd2};
      end
    endcase
    return res;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
      sel_q      <= 2'b00;
      gnt_q      <= 3'b000;
      vld_q      <= 1'b0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      hold_cnt   <= hold_cnt_n;
      sel_q      <= sel_n;
      gnt_q      <= gnt_n;
      vld_q      <= vld_n;
    end
  end

  // Next state: hold, hand off with no bubble, or fall back to idle.
  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    hold_cnt_n   = hold_cnt;
    sel_n        = sel_q;
    gnt_n        = gnt_q;
    vld_n        = vld_q;

    {found, win} = rr_pick(last_owner, bus.req);
    // In GRANT the registered one-hot grant identifies the owner.
    owner_req    = |(bus.req & gnt_q);

    case (state)
      IDLE: begin
        if (found) begin
          state_n      = GRANT;
          last_owner_n = win;
          hold_cnt_n   = HOLD_ONE;
          sel_n        = win;
          gnt_n        = onehot3(win);
          vld_n        = 1'b1;
        end else begin
          sel_n = 2'b00;
          gnt_n = 3'b000;
          vld_n = 1'b0;
        end
      end
      GRANT: begin
        if (owner_req && (hold_cnt < HOLD_MAX)) begin
          hold_cnt_n = hold_cnt + HOLD_ONE;
        end else if (found) begin
          last_owner_n = win;
          hold_cnt_n   = HOLD_ONE;
          sel_n        = win;
          gnt_n        = onehot3(win);
          vld_n        = 1'b1;
        end else begin
          state_n    = IDLE;
          hold_cnt_n = '0;
          sel_n      = 2'b00;
          gnt_n      = 3'b000;
          vld_n      = 1'b0;
        end
      end
      default: begin
        state_n    = IDLE;
        hold_cnt_n = '0;
        sel_n      = 2'b00;
        gnt_n      = 3'b000;
        vld_n      = 1'b0;
      end
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;

endmodule
